// File: rtl/clk_gen_pkg.sv
// Shared definitions for the ring-oscillator clock downsampler.
// Provides the controller state encoding and the default counter width and
// reset ratio used as parameter defaults by every file of the block.
package clk_gen_pkg;

  localparam int unsigned CLK_GEN_WIDTH       = 8;
  localparam int unsigned CLK_GEN_RESET_RATIO = 3;

  // RUN: counting, ratio request accepted
  // PEND: counting, a new ratio waits for the next falling toggle
  // GATED: clk_o parked low, counter held at zero
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_PEND  = 2'd1,
    ST_GATED = 2'd2
  } clk_gen_state_e;

endpackage

// File: rtl/clk_gen_downsample_if.sv
// Ratio reconfiguration handshake for clk_gen_downsample.
//   cfg_v     : new ratio valid            (master -> slave)
//   cfg_ratio : requested ratio R          (master -> slave)
//   cfg_ready : ratio accepted this cycle  (slave -> master)
interface clk_gen_downsample_if #(
  parameter int unsigned width_p = clk_gen_pkg::CLK_GEN_WIDTH
) ();

  logic               cfg_v;
  logic [width_p-1:0] cfg_ratio;
  logic               cfg_ready;

  modport master (output cfg_v, output cfg_ratio, input cfg_ready);
  modport slave  (input cfg_v, input cfg_ratio, output cfg_ready);

endinterface

// File: rtl/clk_gen_ds_counter.sv
// Phase counter for the clock downsampler.
//   clk_i, reset_i : oscillator clock, synchronous active-high reset
//   run_i          : advance the counter this cycle
//   clr_i          : force the counter to zero (wins over run_i)
//   ratio_i        : terminal value R; a phase spans counts 0..R
//   tc_o           : terminal-count strobe, high while running at count R
module clk_gen_ds_counter #(
  parameter int unsigned width_p = clk_gen_pkg::CLK_GEN_WIDTH
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               run_i,
  input  logic               clr_i,
  input  logic [width_p-1:0] ratio_i,
  output logic               tc_o
);

  logic [width_p-1:0] cnt_q;
  logic [width_p-1:0] cnt_d;
  logic               at_ratio;

  assign at_ratio = (cnt_q == ratio_i);
  assign tc_o     = run_i & at_ratio;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (run_i) begin
      cnt_d = at_ratio ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/clk_gen_downsample.sv
// Programmable 50%-duty clock divider clocked by the ring oscillator.
//   clk_i       : oscillator clock (sole clock)
//   reset_i     : synchronous active-high reset
//   en_i        : 1 = run, 0 = park clk_o low at the next falling toggle
//   cfg         : ratio handshake (slave side)
//   clk_o       : divided clock, period 2*(R+1) clk_i cycles, registered
//   tick_o      : one-cycle pulse in the first cycle clk_o reads 1
//   cur_ratio_o : ratio currently in effect
// Ratio changes requested while running only land on a falling toggle of
// clk_o, so every phase is a whole number of old- or new-ratio lengths.
module clk_gen_downsample #(
  parameter int unsigned width_p       = clk_gen_pkg::CLK_GEN_WIDTH,
  parameter int unsigned reset_ratio_p = clk_gen_pkg::CLK_GEN_RESET_RATIO
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    en_i,
  clk_gen_downsample_if.slave     cfg,
  output logic                    clk_o,
  output logic                    tick_o,
  output logic [width_p-1:0]      cur_ratio_o
);

  import clk_gen_pkg::*;

  clk_gen_state_e     state_q, state_d;
  logic               clk_q, clk_d;
  logic               tick_q, tick_d;
  logic [width_p-1:0] ratio_q, ratio_d;
  logic [width_p-1:0] pend_q, pend_d;

  logic cnt_run;
  logic cnt_clr;
  logic cnt_tc;
  logic cfg_ready;
  logic accept;
  logic fall;

  clk_gen_ds_counter #(
    .width_p (width_p)
  ) u_counter (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .run_i   (cnt_run),
    .clr_i   (cnt_clr),
    .ratio_i (ratio_q),
    .tc_o    (cnt_tc)
  );

  assign cfg_ready     = ~reset_i & (state_q != ST_PEND);
  assign cfg.cfg_ready = cfg_ready;
  assign accept        = cfg.cfg_v & cfg_ready;
  assign fall          = cnt_tc & clk_q;

  always_comb begin
    state_d = state_q;
    clk_d   = clk_q;
    tick_d  = 1'b0;
    ratio_d = ratio_q;
    pend_d  = pend_q;
    cnt_run = 1'b0;
    cnt_clr = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        cnt_run = 1'b1;
        if (cnt_tc) begin
          clk_d  = ~clk_q;
          tick_d = ~clk_q;
        end
        // An accepted request outranks gating on the same fall; en_i is
        // then re-examined when the pending ratio lands.
        if (accept) begin
          pend_d  = cfg.cfg_ratio;
          state_d = ST_PEND;
        end else if (fall && !en_i) begin
          state_d = ST_GATED;
        end
      end

      ST_PEND: begin
        cnt_run = 1'b1;
        if (cnt_tc) begin
          clk_d  = ~clk_q;
          tick_d = ~clk_q;
        end
        // Counter already wraps to zero on terminal count; the clear just
        // makes the restart explicit for the new ratio's low phase.
        if (fall) begin
          ratio_d = pend_q;
          cnt_clr = 1'b1;
          state_d = en_i ? ST_RUN : ST_GATED;
        end
      end

      ST_GATED: begin
        cnt_clr = 1'b1;
        clk_d   = 1'b0;
        if (accept) begin
          ratio_d = cfg.cfg_ratio;
        end
        if (en_i) begin
          state_d = ST_RUN;
        end
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_RUN;
      clk_q   <= 1'b0;
      tick_q  <= 1'b0;
      ratio_q <= width_p'(reset_ratio_p);
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      clk_q   <= clk_d;
      tick_q  <= tick_d;
      ratio_q <= ratio_d;
      pend_q  <= pend_d;
    end
  end

  assign clk_o       = clk_q;
  assign tick_o      = tick_q;
  assign cur_ratio_o = ratio_q;

endmodule
